// File: rtl/snowbro2_pcm_pkg.sv
// snowbro2 PCM sample-ROM cache: shared types and helpers.
// Holds the fill FSM state type, the line geometry and the byte selector.
package snowbro2_pcm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        GAP
    } state_t;

    localparam int PCM_LINE_WORDS = 4;
    localparam int LINE_BYTES     = PCM_LINE_WORDS * 2;
    localparam int OFFSET_W       = $clog2(LINE_BYTES);

    // Little-endian byte lanes: even byte in [7:0], odd byte in [15:8].
    function automatic logic [7:0] byte_sel(input logic [15:0] w,
                                            input logic odd);
        return odd ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/snowbro2_pcm_line.sv
// snowbro2 PCM cache line: word storage, tag/valid, tag compare, byte mux.
// Ports: clk, rst, clr (invalidate), we/widx/wdata (fill write),
//        commit/ctag (mark line valid), addr (lookup), hit, rbyte.
module snowbro2_pcm_line
    import snowbro2_pcm_pkg::*;
#(
    parameter int AW         = 20,
    parameter int LINE_WORDS = PCM_LINE_WORDS,
    localparam int OW        = $clog2(LINE_WORDS * 2),
    localparam int IW        = OW - 1,
    localparam int TW        = AW - OW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [15:0]   wdata,
    input  logic          commit,
    input  logic [TW-1:0] ctag,
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic [7:0]    rbyte
);

    logic [15:0]   words [LINE_WORDS];
    logic [TW-1:0] tag;
    logic          valid;

    always_ff @(posedge clk) begin
        if (we)
            words[widx] <= wdata;
    end

    // Invalidation beats commit so an abort never leaves a half line valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (commit) begin
            valid <= 1'b1;
            tag   <= ctag;
        end
    end

    assign hit   = valid && (addr[AW-1:OW] == tag);
    assign rbyte = byte_sel(words[addr[OW-1:1]], addr[0]);

endmodule

// File: rtl/snowbro2_pcm_rom.sv
// snowbro2 ADPCM sample-ROM responder: one-line cache refilled from SDRAM.
// Ports: CLK96/RESET96, PCM_CS/PCM_ADDR -> PCM_DOUT/PCM_OK (byte side),
//        ROM_CS/ROM_ADDR <- ROM_DATA/ROM_OK (word side), FLUSH.
module snowbro2_pcm_rom
    import snowbro2_pcm_pkg::*;
#(
    parameter int AW         = 20,
    parameter int LINE_WORDS = PCM_LINE_WORDS,
    parameter int RAW        = 19
) (
    input  logic           CLK96,
    input  logic           RESET96,
    input  logic           PCM_CS,
    input  logic [AW-1:0]  PCM_ADDR,
    output logic [7:0]     PCM_DOUT,
    output logic           PCM_OK,
    output logic           ROM_CS,
    output logic [RAW-1:0] ROM_ADDR,
    input  logic [15:0]    ROM_DATA,
    input  logic           ROM_OK,
    input  logic           FLUSH
);

    localparam int OW = $clog2(LINE_WORDS * 2);
    localparam int IW = OW - 1;
    localparam int TW = AW - OW;

    state_t        state;
    logic [IW-1:0] cnt;
    logic [IW-1:0] cnt_nxt;
    logic [TW-1:0] fill_tag;
    logic [TW-1:0] tag_in;
    logic [AW-1:0] addr_reg;
    logic          ok_reg;
    logic          hit;
    logic [7:0]    rbyte;
    logic          busy;
    logic          last;
    logic          start_fill;
    logic          wr_en;
    logic          commit;
    logic          clr;

    assign tag_in     = PCM_ADDR[AW-1:OW];
    assign cnt_nxt    = cnt + 1'b1;
    assign busy       = (state == REQ) || (state == WAIT);
    assign last       = (cnt == IW'(LINE_WORDS - 1));
    assign start_fill = (state == IDLE) && PCM_CS && !hit && !FLUSH;
    assign wr_en      = busy && ROM_OK && !FLUSH;
    assign commit     = (state == GAP) && last && !FLUSH;
    // Line goes invalid the moment a fill starts, so stale data is never served.
    assign clr        = FLUSH || start_fill;

    snowbro2_pcm_line #(
        .AW         (AW),
        .LINE_WORDS (LINE_WORDS)
    ) u_line (
        .clk    (CLK96),
        .rst    (RESET96),
        .clr    (clr),
        .we     (wr_en),
        .widx   (cnt),
        .wdata  (ROM_DATA),
        .commit (commit),
        .ctag   (fill_tag),
        .addr   (PCM_ADDR),
        .hit    (hit),
        .rbyte  (rbyte)
    );

    // OK is only trusted while the requester still presents the same address.
    assign PCM_OK = ok_reg && (addr_reg == PCM_ADDR) && PCM_CS;

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            state    <= IDLE;
            cnt      <= '0;
            fill_tag <= '0;
            addr_reg <= '0;
            ok_reg   <= 1'b0;
            PCM_DOUT <= 8'h00;
            ROM_CS   <= 1'b0;
            ROM_ADDR <= '0;
        end else if (FLUSH) begin
            state  <= IDLE;
            cnt    <= '0;
            ok_reg <= 1'b0;
            ROM_CS <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    ok_reg <= PCM_CS && hit;
                    if (PCM_CS && hit) begin
                        PCM_DOUT <= rbyte;
                        addr_reg <= PCM_ADDR;
                    end else if (PCM_CS) begin
                        fill_tag <= tag_in;
                        cnt      <= '0;
                        ROM_CS   <= 1'b1;
                        ROM_ADDR <= {tag_in, {IW{1'b0}}};
                        state    <= REQ;
                    end
                end
                REQ, WAIT: begin
                    ok_reg <= 1'b0;
                    if (ROM_OK) begin
                        ROM_CS <= 1'b0;
                        state  <= GAP;
                    end else begin
                        state  <= WAIT;
                    end
                end
                GAP: begin
                    ok_reg <= 1'b0;
                    if (!last) begin
                        cnt      <= cnt_nxt;
                        ROM_CS   <= 1'b1;
                        ROM_ADDR <= {fill_tag, cnt_nxt};
                        state    <= REQ;
                    end else begin
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snowbro2_pcm_rom.sv
// Self-checking bench for snowbro2_pcm_rom with a scoreboard of expected
// ROM word requests and PCM bytes, and a delayed-response ROM model.
module tb_snowbro2_pcm_rom;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcm_cs;
    logic [19:0] pcm_addr;
    logic [7:0]  pcm_dout;
    logic        pcm_ok;
    logic        rom_cs;
    logic [18:0] rom_addr;
    logic [15:0] rom_data;
    logic        rom_ok;
    logic        flush;

    always #5 clk = ~clk;

    snowbro2_pcm_rom dut (
        .CLK96    (clk),
        .RESET96  (rst),
        .PCM_CS   (pcm_cs),
        .PCM_ADDR (pcm_addr),
        .PCM_DOUT (pcm_dout),
        .PCM_OK   (pcm_ok),
        .ROM_CS   (rom_cs),
        .ROM_ADDR (rom_addr),
        .ROM_DATA (rom_data),
        .ROM_OK   (rom_ok),
        .FLUSH    (flush)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_rok = 0;
    int          low_run = 0;
    int          dly = 0;
    bit          prev_cs = 1'b0;
    bit          no_ok = 1'b0;
    bit          hold_w2 = 1'b0;
    bit          manual_ok = 1'b0;
    logic [18:0] req_addr = '0;
    logic [18:0] exp_addr [$];
    logic [7:0]  exp_byte [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rb(input logic [19:0] b);
        return 8'(b[7:0] * 8'h11) ^ b[19:12];
    endfunction

    function automatic logic [15:0] word(input logic [18:0] a);
        return {rb({a, 1'b1}), rb({a, 1'b0})};
    endfunction

    task automatic push_line(input logic [19:0] a);
        for (int k = 0; k < 4; k++)
            exp_addr.push_back({a[19:3], 2'(k)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ROM responder plus request/handshake monitor, sampled on the falling edge.
    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (rom_ok) begin
                rom_ok = 1'b0;
            end else if (manual_ok) begin
                rom_ok    = 1'b1;
                rom_data  = 16'hBEEF;
                manual_ok = 1'b0;
            end else if (rom_cs && !(hold_w2 && rom_addr[1:0] == 2'd2)) begin
                if (dly == 2) begin
                    rom_ok   = 1'b1;
                    rom_data = word(rom_addr);
                    dly      = 0;
                    last_rok = cyc;
                end else begin
                    dly++;
                end
            end
            if (!rom_cs)
                dly = 0;
            if (rom_cs && !prev_cs) begin
                if (rom_addr[1:0] != 2'd0)
                    chk("rom_gap", low_run, 1);
                if (exp_addr.size() == 0)
                    chk("rom_extra", exp_addr.size(), 1);
                else
                    chk("rom_addr", rom_addr, exp_addr.pop_front());
                req_addr = rom_addr;
                low_run  = 0;
            end
            if (!rom_cs)
                low_run++;
            if (rom_cs && rom_ok)
                chk("rom_stable", rom_addr, req_addr);
            if (no_ok)
                chk("ok_quiet", pcm_ok, 0);
            prev_cs = rom_cs;
        end
    endtask

    task automatic wait_rom(input string tag, input logic [18:0] a);
        int n = 0;
        while (!(rom_cs && rom_addr == a) && n < 200) begin
            step();
            n++;
        end
        chk(tag, {rom_cs, rom_addr}, {1'b1, a});
    endtask

    task automatic wait_ok(input string tag, input bit miss);
        int n = 0;
        #1;
        while (!pcm_ok && n < 300) begin
            step();
            n++;
        end
        chk({tag, "_ok"}, pcm_ok, 1);
        if (exp_byte.size() > 0)
            chk({tag, "_byte"}, pcm_dout, exp_byte.pop_front());
        if (miss)
            chk({tag, "_lat"}, cyc - last_rok, 2);
        chk({tag, "_romq"}, exp_addr.size(), 0);
    endtask

    initial begin
        rst      = 1'b1;
        pcm_cs   = 1'b0;
        pcm_addr = '0;
        flush    = 1'b0;
        rom_ok   = 1'b0;
        rom_data = '0;
        fork
            monitor();
        join_none
        repeat (3) step();
        chk("rst_dout", pcm_dout, 0);
        chk("rst_ok", pcm_ok, 0);
        chk("rst_romcs", rom_cs, 0);
        chk("rst_romaddr", rom_addr, 0);
        rst = 1'b0;

        // cold miss
        pcm_cs   = 1'b1;
        pcm_addr = 20'h00005;
        push_line(20'h00005);
        exp_byte.push_back(rb(20'h00005));
        wait_ok("cold", 1'b1);

        // hit stream, one address per cycle
        for (int i = 0; i < 8; i++) begin
            pcm_addr = 20'(i);
            exp_byte.push_back(rb(20'(i)));
            #1;
            chk("hit_chg_ok", pcm_ok, 0);
            step();
            chk("hit_ok", pcm_ok, 1);
            chk("hit_byte", pcm_dout, exp_byte.pop_front());
            chk("hit_romcs", rom_cs, 0);
        end

        // line change during a fill
        no_ok    = 1'b1;
        pcm_addr = 20'h00008;
        push_line(20'h00008);
        wait_rom("lc_w1", 19'h00005);
        pcm_addr = 20'h00010;
        push_line(20'h00010);
        exp_byte.push_back(rb(20'h00010));
        wait_rom("lc_w11", 19'h0000B);
        no_ok = 1'b0;
        wait_ok("lc", 1'b1);

        // flush in WAIT for word 2, late ROM_OK
        no_ok    = 1'b1;
        hold_w2  = 1'b1;
        pcm_addr = 20'h00020;
        for (int k = 0; k < 3; k++)
            exp_addr.push_back(19'h00010 + 19'(k));
        wait_rom("fl_w2", 19'h00012);
        step();
        flush  = 1'b1;
        pcm_cs = 1'b0;
        step();
        flush = 1'b0;
        chk("fl_romcs", rom_cs, 0);
        hold_w2 = 1'b0;
        step();
        manual_ok = 1'b1;
        repeat (4) step();
        chk("fl_late_cs", rom_cs, 0);
        pcm_cs = 1'b1;
        push_line(20'h00020);
        exp_byte.push_back(rb(20'h00020));
        wait_rom("fl_w3", 19'h00013);
        no_ok = 1'b0;
        wait_ok("fl_refill", 1'b1);
        pcm_addr = 20'h00024;
        exp_byte.push_back(rb(20'h00024));
        wait_ok("fl_hit", 1'b0);

        // flush colliding with a hit
        pcm_addr = 20'h00021;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        chk("coll_ok", pcm_ok, 0);
        push_line(20'h00021);
        exp_byte.push_back(rb(20'h00021));
        wait_ok("coll", 1'b1);

        // top of the address space
        pcm_addr = 20'hFFFFF;
        push_line(20'hFFFFF);
        exp_byte.push_back(rb(20'hFFFFF));
        wait_ok("top", 1'b1);

        // request dropped
        pcm_cs = 1'b0;
        #1;
        chk("cs0_ok", pcm_ok, 0);
        step();
        chk("cs0_romcs", rom_cs, 0);

        // reset in the middle of a fill
        pcm_cs   = 1'b1;
        pcm_addr = 20'h00040;
        exp_addr.push_back(19'h00020);
        wait_rom("rs_w0", 19'h00020);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs_romcs", rom_cs, 0);
        chk("rs_dout", pcm_dout, 0);
        chk("rs_ok", pcm_ok, 0);
        push_line(20'h00040);
        exp_byte.push_back(rb(20'h00040));
        wait_ok("rs", 1'b1);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/snowbro2_pcm_rom.md
Name: snowbro2_pcm_rom

Overview:
- Responder side of the ADPCM sample-ROM fetch interface.
- Serves the OKI sample-ROM byte requests (PCM_CS/PCM_ADDR -> PCM_DOUT/PCM_OK) for the snowbro2 sound block.
- Holds one cached line of 16-bit SDRAM words and refills it through a request/ok word port into the SDRAM arbiter slot.
- Sits between snowbro2_sound and the SDRAM controller; the bank-adjusted byte address arrives already formed.

Parameters:
- AW, 20, PCM byte-address width.
- LINE_WORDS, 4, 16-bit words per cached line (power of two, 2..16).
- RAW, 19, ROM word-address width (AW-1).

Ports:
- CLK96  input  1  sound clock; all logic on rising edge.
- RESET96  input  1  synchronous, active-high reset.
- PCM_CS  input  1  byte request valid.
- PCM_ADDR  input  AW  requested byte address.
- PCM_DOUT  output  8  byte for PCM_ADDR.
- PCM_OK  output  1  PCM_DOUT valid for the current PCM_ADDR.
- ROM_CS  output  1  SDRAM word request.
- ROM_ADDR  output  RAW  SDRAM word address.
- ROM_DATA  input  16  SDRAM word; valid while ROM_OK=1.
- ROM_OK  input  1  one-cycle data strobe for the current ROM_ADDR.
- FLUSH  input  1  invalidate line (ROM download or bank reload).

Behaviour:
- Address split:
  - offset = PCM_ADDR[log2(LINE_WORDS*2)-1:0].
  - tag = the remaining upper bits.
  - word index = offset[msb:1].
  - Even byte is taken from ROM_DATA[7:0], odd byte from [15:8].
- Reset values: PCM_DOUT=0, PCM_OK=0, ROM_CS=0, ROM_ADDR=0, line valid=0, state=IDLE, word counter=0.
- Lookup (IDLE, every cycle):
  - On PCM_CS & valid & tag hit, register the byte and the address at cycle t. PCM_DOUT is updated at t+1.
  - PCM_OK = ok_reg & (addr_reg == PCM_ADDR) & PCM_CS. This is a combinational qualifier, so an address change drops OK in the same cycle.
  - Hit-to-OK latency is 1 cycle.
- States: IDLE, REQ, WAIT, GAP.
  - IDLE: PCM_CS & miss at t -> latch fill tag, counter=0, state REQ. ROM_CS=1 at t+1 with ROM_ADDR = {tag, counter}.
  - REQ/WAIT: ROM_CS held 1 with a stable ROM_ADDR until ROM_OK. On ROM_OK at u, store the word at index counter and deassert ROM_CS at u+1 (state GAP).
  - GAP: one cycle with ROM_CS=0.
    - If counter < LINE_WORDS-1: increment and return to REQ (ROM_CS=1 at u+2).
    - Else: valid=1, tag committed, state IDLE.
  - Miss-to-OK latency: the first PCM_OK appears 2 cycles after the final ROM_OK (GAP, then lookup register).
- Fill order is always word 0 upward; there is no critical-word-first.
  - PCM_OK stays 0 during a fill, even for bytes already received.
- A PCM_ADDR change to another line during a fill does not abort it. The fill completes, then the new address misses and starts a new fill.
- valid=0 from the start of a fill until its completion; old line contents are not served mid-fill.
- FLUSH:
  - In IDLE: valid=0 next cycle, ok_reg=0.
  - In REQ/WAIT/GAP: abort, ROM_CS=0 next cycle, valid=0, state IDLE, counter=0. A ROM_OK arriving while ROM_CS=0 is ignored.
  - FLUSH coincident with a hit: FLUSH wins, and PCM_OK=0 next cycle.
- RESET96 mid-fill: same effect as FLUSH plus all reset values. Late ROM_OK is ignored.
- PCM_CS=0: no new fill starts and PCM_OK=0. An active fill still completes.
- Tag wrap: the top line (all-ones tag) fills word addresses up to 2^RAW-1 with no overflow.

Decomposition:
- Package snowbro2_pcm_pkg:
  - state enum {IDLE, REQ, WAIT, GAP}.
  - LINE_BYTES and OFFSET_W localparams derived from LINE_WORDS.
  - byte-select function.
- One sub-module, snowbro2_pcm_line:
  - word array, tag and valid registers.
  - tag compare and byte mux.
  - write port driven by the FSM.
- The FSM and ROM port remain in the top module.

Test Plan:
- Cold miss: reset, PCM_CS=1, PCM_ADDR=0x00005, ROM returns 0x1100/0x3322/0x5544/0x7766 with ROM_OK 3 cycles after each ROM_CS.
  - Required: ROM_ADDR 0x00000..0x00003 with a 1-cycle ROM_CS gap between requests.
  - PCM_DOUT=0x55 and PCM_OK=1 two cycles after the last ROM_OK.
- Hit stream: after the fill, step PCM_ADDR 0x00000..0x00007 one per cycle.
  - Required: bytes 0x00,0x11,0x22..0x77, each with 1-cycle latency.
  - PCM_OK=0 in any cycle where the address just changed; ROM_CS stays 0.
- Line change mid-fill: switch PCM_ADDR to 0x00010 during word 1.
  - Required: the current fill finishes (4 words), then a new fill of words 0x00008..0x0000B starts.
  - PCM_OK only after the second fill completes.
- FLUSH mid-fill: assert during WAIT for word 2, then pulse ROM_OK 2 cycles later.
  - Required: ROM_CS=0 next cycle and the late ROM_OK is ignored.
  - The next request refills from word 0, and PCM_OK=0 throughout.
- FLUSH plus hit collision: FLUSH and a hitting request in the same cycle.
  - Required: PCM_OK=0 next cycle, then a full refill.
- Top address: PCM_ADDR=0xFFFFF.
  - Required: ROM_ADDR 0x7FFFC..0x7FFFF, PCM_DOUT = high byte of word 0x7FFFF.
